gen_txen_dat: RTL and testbench



---
 rtl/gen_txen_dat_pkg.sv | 35 +++
 rtl/gen_txen_dat_word_src.sv | 30 +++
 rtl/gen_txen_dat.sv | 128 ++++++++++++
 tb/tb_gen_txen_dat.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_txen_dat_pkg.sv
// Shared types and constants for gen_txen_dat.
// FSM states, command-word field layout, LFSR seed/taps.
package gen_txen_dat_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CW   = 2'd1,
        S_GAP  = 2'd2,
        S_DW   = 2'd3
    } state_t;

    localparam int WORD_W = 16;

    // Command word layout: {rt_addr, tr, subaddr, word_cnt}
    localparam int RT_W  = 5;
    localparam int TR_W  = 1;
    localparam int SA_W  = 5;
    localparam int WC_W  = 5;
    localparam int WC_LSB = 0;
    localparam int SA_LSB = WC_LSB + WC_W;
    localparam int TR_LSB = SA_LSB + SA_W;
    localparam int RT_LSB = TR_LSB + TR_W;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form:
    // feedback from bits 0,2,3,5 enters at bit 15.
    localparam logic [WORD_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [WORD_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [WORD_W-1:0] lfsr_step(
        input logic [WORD_W-1:0] w
    );
        return {^(w & LFSR_TAPS), w[WORD_W-1:1]};
    endfunction

endpackage

// File: rtl/gen_txen_dat_word_src.sv
// Data-word source: incrementing counter, or LFSR when
// GEN_TXEN_DAT_PRBS_EN is defined. Ports: clk, rst_n, adv (step), word.
module gen_txen_dat_word_src
    import gen_txen_dat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [WORD_W-1:0] word
);

`ifdef GEN_TXEN_DAT_PRBS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= LFSR_SEED;
        end else if (adv) begin
            word <= lfsr_step(word);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (adv) begin
            word <= word + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/gen_txen_dat.sv
// Transmit stimulus generator: on st emits CW_TX then DW_TX on DAT framed by txen.
// Ports: clk, rst_n, st in; txen, DAT, CW_TX, DW_TX out. Option: GEN_TXEN_DAT_PRBS_EN.
module gen_txen_dat
    import gen_txen_dat_pkg::*;
#(
    parameter int              BIT_CLKS  = 50,
    parameter int              WORD_BITS = 20,
    parameter int              GAP_CLKS  = 100,
    parameter logic [RT_W-1:0] RT_ADDR   = 5'd1,
    parameter logic [TR_W-1:0] TR_BIT    = 1'b0,
    parameter logic [SA_W-1:0] SUBADDR   = 5'd2,
    parameter logic [WC_W-1:0] WORD_CNT  = 5'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st,
    output logic              txen,
    output logic [WORD_W-1:0] DAT,
    output logic [WORD_W-1:0] CW_TX,
    output logic [WORD_W-1:0] DW_TX
);

    localparam int WORD_CLKS = BIT_CLKS * WORD_BITS;
    localparam int MAX_CLKS  = (WORD_CLKS > GAP_CLKS) ? WORD_CLKS : GAP_CLKS;
    localparam int TW        = $clog2(MAX_CLKS + 1);

    // Timer counts down to zero, so a load of N-1 gives N cycles.
    localparam logic [TW-1:0] WORD_LD = TW'(WORD_CLKS - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CLKS - 1);

    localparam logic [WORD_W-1:0] CW_VAL =
        {RT_ADDR, TR_BIT, SUBADDR, WORD_CNT};

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              txen_d;
    logic [WORD_W-1:0] dat_d;
    logic [WORD_W-1:0] cw_d;
    logic [WORD_W-1:0] dw_d;
    logic              adv;
    logic [WORD_W-1:0] src_word;
    logic              tmr_zero;

    assign tmr_zero = (timer_q == '0);

    gen_txen_dat_word_src u_src (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .word  (src_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            txen    <= 1'b0;
            DAT     <= '0;
            CW_TX   <= '0;
            DW_TX   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            txen    <= txen_d;
            DAT     <= dat_d;
            CW_TX   <= cw_d;
            DW_TX   <= dw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        txen_d  = txen;
        dat_d   = DAT;
        cw_d    = CW_TX;
        dw_d    = DW_TX;
        adv     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (st) begin
                    state_d = S_CW;
                    timer_d = WORD_LD;
                    txen_d  = 1'b1;
                    dat_d   = CW_VAL;
                    cw_d    = CW_VAL;
                    dw_d    = src_word;
                end
            end
            S_CW: begin
                if (tmr_zero) begin
                    state_d = S_GAP;
                    timer_d = GAP_LD;
                    txen_d  = 1'b0;
                    dat_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_zero) begin
                    state_d = S_DW;
                    timer_d = WORD_LD;
                    txen_d  = 1'b1;
                    dat_d   = DW_TX;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DW: begin
                if (tmr_zero) begin
                    // Source steps only once the data word is fully sent.
                    state_d = S_IDLE;
                    timer_d = '0;
                    txen_d  = 1'b0;
                    dat_d   = '0;
                    adv     = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gen_txen_dat.sv
// Self-checking bench for gen_txen_dat with a frame scoreboard.
// Covers reset, frames, ignored st, back-to-back, abort, counter wrap.
module tb_gen_txen_dat;

    localparam int BIT_CLKS  = 2;
    localparam int WORD_BITS = 4;
    localparam int WORD_CLKS = BIT_CLKS * WORD_BITS;
    localparam int GAP_CLKS  = 3;
    localparam logic [4:0] RT = 5'd1;
    localparam logic       TR = 1'b0;
    localparam logic [4:0] SA = 5'd1;
    localparam logic [4:0] WC = 5'd2;
    localparam logic [15:0] EXP_CW = {RT, TR, SA, WC};

`ifdef GEN_TXEN_DAT_PRBS_EN
    localparam logic [15:0] SRC_INIT = 16'hACE1;
`else
    localparam logic [15:0] SRC_INIT = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic        txen;
    logic [15:0] DAT;
    logic [15:0] CW_TX;
    logic [15:0] DW_TX;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] word;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] src_m;
    logic [15:0] last_dw;

    always #5 clk = ~clk;

    gen_txen_dat #(
        .BIT_CLKS  (BIT_CLKS),
        .WORD_BITS (WORD_BITS),
        .GAP_CLKS  (GAP_CLKS),
        .RT_ADDR   (RT),
        .TR_BIT    (TR),
        .SUBADDR   (SA),
        .WORD_CNT  (WC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (st),
        .txen  (txen),
        .DAT   (DAT),
        .CW_TX (CW_TX),
        .DW_TX (DW_TX)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] w);
`ifdef GEN_TXEN_DAT_PRBS_EN
        logic fb;
        fb = w[0] ^ w[2] ^ w[3] ^ w[5];
        return (w >> 1) | {fb, 15'd0};
`else
        return w + 16'd1;
`endif
    endfunction

    // Queue one transaction; idle_gap < 0 means do not check it.
    task automatic push_txn(input int idle_gap);
        exp_t e;
        e.word = EXP_CW;
        e.gap  = idle_gap;
        exp_q.push_back(e);
        e.word = src_m;
        e.gap  = GAP_CLKS;
        exp_q.push_back(e);
        last_dw = src_m;
        src_m   = nxt(src_m);
    endtask

    // One-clock st pulse from idle, with latency check.
    task automatic start_pulse();
        push_txn(-1);
        st = 1'b1;
        chk("lat_pre", {31'd0, txen}, 32'd0);
        @(negedge clk);
        st = 1'b0;
        chk("lat_post", {31'd0, txen}, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || txen) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        if (k >= 200) chk("timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops an expected word at each txen rise and
    // checks word length, gap length and DAT content.
    initial begin
        bit          in_run;
        int          len;
        int          gap;
        logic [15:0] cur;
        exp_t        e;
        in_run = 1'b0;
        len    = 0;
        gap    = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_run = 1'b0;
                gap    = 0;
                exp_q.delete();
            end else if (txen) begin
                if (!in_run) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                        cur = '0;
                    end else begin
                        e = exp_q.pop_front();
                        if (e.gap >= 0) chk("gap_len", gap, e.gap);
                        cur = e.word;
                    end
                    in_run = 1'b1;
                    len    = 0;
                end
                len++;
                chk("dat", {16'd0, DAT}, {16'd0, cur});
            end else begin
                if (in_run) begin
                    chk("word_len", len, WORD_CLKS);
                    in_run = 1'b0;
                    gap    = 0;
                end
                gap++;
                chk("dat_idle", {16'd0, DAT}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        st      = 1'b0;
        src_m   = SRC_INIT;
        last_dw = SRC_INIT;
        repeat (3) @(negedge clk);
        chk("rst_txen", {31'd0, txen}, 32'd0);
        chk("rst_dat", {16'd0, DAT}, 32'd0);
        chk("rst_cw", {16'd0, CW_TX}, 32'd0);
        chk("rst_dw", {16'd0, DW_TX}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_txen", {31'd0, txen}, 32'd0);
        chk("idle_cw", {16'd0, CW_TX}, 32'd0);

        // First single frame
        start_pulse();
        wait_idle();
        chk("cw_hold1", {16'd0, CW_TX}, {16'd0, EXP_CW});
        chk("dw_hold1", {16'd0, DW_TX}, {16'd0, last_dw});

        // Second frame with st pulses during CW, GAP, DW
        start_pulse();
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            st = (i == 3 || i == 9 || i == 14 || i == 18);
        end
        @(negedge clk);
        st = 1'b0;
        wait_idle();
        chk("dw_hold2", {16'd0, DW_TX}, {16'd0, last_dw});

        // st held high: three frames, one idle cycle apart
        push_txn(-1);
        push_txn(1);
        push_txn(1);
        st = 1'b1;
        repeat (45) @(negedge clk);
        st = 1'b0;
        wait_idle();
        chk("dw_hold3", {16'd0, DW_TX}, {16'd0, last_dw});

        // Reset during DW
        push_txn(-1);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_abort_txen", {31'd0, txen}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_txen", {31'd0, txen}, 32'd0);
        chk("abort_dat", {16'd0, DAT}, 32'd0);
        chk("abort_dw", {16'd0, DW_TX}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        src_m = SRC_INIT;
        @(negedge clk);
        start_pulse();
        wait_idle();
        chk("restart_dw", {16'd0, DW_TX}, {16'd0, SRC_INIT});

`ifndef GEN_TXEN_DAT_PRBS_EN
        // Counter wrap via preload
        force dut.u_src.word = 16'hFFFF;
        #1;
        release dut.u_src.word;
        src_m = 16'hFFFF;
        @(negedge clk);
        start_pulse();
        wait_idle();
        chk("wrap_ffff", {16'd0, DW_TX}, 32'h0000FFFF);
        start_pulse();
        wait_idle();
        chk("wrap_0000", {16'd0, DW_TX}, 32'h00000000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
